// File: rtl/seq_onehot_decoder_pkg.sv
// Shared definitions for the one-hot ring sequencer and its receive-side decoder.
// Code constants, FSM state type, step classes and ring rotate helpers.
package seq_onehot_decoder_pkg;

  localparam logic [3:0] C0 = 4'b0001;
  localparam logic [3:0] C1 = 4'b0010;
  localparam logic [3:0] C2 = 4'b0100;
  localparam logic [3:0] C3 = 4'b1000;

  localparam int ERR_CNT_W = 8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    STEP_UP      = 2'd0,
    STEP_DN      = 2'd1,
    STEP_JUMP    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_e;

  function automatic logic [3:0] rotl4(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  function automatic logic [3:0] rotr4(input logic [3:0] c);
    return {c[0], c[3:1]};
  endfunction

  function automatic logic is_onehot4(input logic [3:0] c);
    return (c == C0) || (c == C1) || (c == C2) || (c == C3);
  endfunction

endpackage

// File: rtl/seq_onehot_decoder_if.sv
// Bus between the one-hot sequencer side (master) and the decoder (slave).
interface seq_onehot_decoder_if #(
  parameter int W = 8
);
  import seq_onehot_decoder_pkg::*;

  logic [3:0]           In;
  logic                 Xdec;
  logic                 Xvalid;
  logic                 err;
  logic                 locked;
  logic [W-1:0]         word;
  logic                 word_valid;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output In,
    input  Xdec, Xvalid, err, locked, word, word_valid, err_count
  );

  modport slave (
    input  In,
    output Xdec, Xvalid, err, locked, word, word_valid, err_count
  );

endinterface

// File: rtl/seq_onehot_decoder_bit_deserializer.sv
// Packs recovered bits MSB-first into W-bit words; clear discards a partial word.
module bit_deserializer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         bit_i,
  input  logic         valid_i,
  input  logic         clear_i,
  output logic [W-1:0] word_o,
  output logic         word_valid_o
);

  localparam int CNT_W = $clog2(W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [W-1:0]     word_q, word_d;
  logic             word_valid_q, word_valid_d;

  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (valid_i) begin
      shift_d = {shift_q[W-2:0], bit_i};
      if (cnt_q == CNT_W'(W - 1)) begin
        word_d       = shift_d;
        word_valid_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/seq_onehot_decoder.sv
// Receive-side decoder for the 4-bit one-hot ring sequencer: recovers the step
// direction bit, flags illegal/non-adjacent codes and deserializes the bits.
module seq_onehot_decoder
  import seq_onehot_decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  seq_onehot_decoder_if.slave  bus
);

  state_e               state_q, state_d;
  logic [3:0]           prev_q, prev_d;
  logic                 xdec_q, xdec_d;
  logic                 xvalid_q, xvalid_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 clear_d;
  step_e                step;

  // Classify the incoming code against the last accepted one.
  always_comb begin
    step = STEP_JUMP;
    if (!is_onehot4(bus.In))          step = STEP_ILLEGAL;
    else if (bus.In == rotl4(prev_q)) step = STEP_UP;
    else if (bus.In == rotr4(prev_q)) step = STEP_DN;
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    xdec_d   = 1'b0;
    xvalid_d = 1'b0;
    err_d    = 1'b0;
    clear_d  = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (step != STEP_ILLEGAL) begin
          prev_d  = bus.In;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        unique case (step)
          STEP_UP: begin
            xvalid_d = 1'b1;
            xdec_d   = 1'b1;
            prev_d   = bus.In;
          end
          STEP_DN: begin
            xvalid_d = 1'b1;
            prev_d   = bus.In;
          end
          STEP_JUMP: begin
            err_d   = 1'b1;
            clear_d = 1'b1;
            prev_d  = bus.In;
          end
          default: begin
            // Illegal code: drop lock; the next one-hot sample relocks silently.
            err_d   = 1'b1;
            clear_d = 1'b1;
            state_d = HUNT;
          end
        endcase
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      prev_q    <= '0;
      xdec_q    <= 1'b0;
      xvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      xdec_q    <= xdec_d;
      xvalid_q  <= xvalid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Fed from next-state values so word_valid lines up with the W-th Xvalid.
  bit_deserializer #(.W(W)) u_deser (
    .CLK          (CLK),
    .reset        (reset),
    .bit_i        (xdec_d),
    .valid_i      (xvalid_d),
    .clear_i      (clear_d),
    .word_o       (bus.word),
    .word_valid_o (bus.word_valid)
  );

  assign bus.Xdec      = xdec_q;
  assign bus.Xvalid    = xvalid_q;
  assign bus.err       = err_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Table-driven bench for seq_onehot_decoder with hand-derived expected outputs.
module tb_seq_onehot_decoder;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  seq_onehot_decoder_if #(.W(W)) bus();

  seq_onehot_decoder #(.W(W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] in;
    logic       xv;
    logic       xd;
    logic       er;
    logic       lk;
    logic       wv;
    logic [7:0] wd;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h required %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] in, input logic xv, input logic xd,
                              input logic er, input logic lk, input logic wv,
                              input logic [7:0] wd, input logic [7:0] ec);
    vec_t v;
    v.in = in; v.xv = xv; v.xd = xd; v.er = er;
    v.lk = lk; v.wv = wv; v.wd = wd; v.ec = ec;
    tbl.push_back(v);
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge CLK);
    bus.In = v.in;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk("Xvalid", 16'(bus.Xvalid), 16'(e.xv));
      if (e.xv) chk("Xdec", 16'(bus.Xdec), 16'(e.xd));
      chk("err", 16'(bus.err), 16'(e.er));
      chk("locked", 16'(bus.locked), 16'(e.lk));
      chk("word_valid", 16'(bus.word_valid), 16'(e.wv));
      chk("word", 16'(bus.word), 16'(e.wd));
      chk("err_count", 16'(bus.err_count), 16'(e.ec));
    end
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_Xdec"}, 16'(bus.Xdec), 16'd0);
    chk({tag, "_Xvalid"}, 16'(bus.Xvalid), 16'd0);
    chk({tag, "_err"}, 16'(bus.err), 16'd0);
    chk({tag, "_locked"}, 16'(bus.locked), 16'd0);
    chk({tag, "_word"}, 16'(bus.word), 16'd0);
    chk({tag, "_word_valid"}, 16'(bus.word_valid), 16'd0);
    chk({tag, "_err_count"}, 16'(bus.err_count), 16'd0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    #1;
    reset  = 1'b1;
    bus.In = 4'b0000;
    #1;
    chk_zero(tag);
    @(negedge CLK);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.In = 4'b0000;
    reset  = 1'b1;
    repeat (2) @(negedge CLK);
    chk_zero("reset");
    reset = 1'b0;

    // Illegal codes while hunting, then lock and four upward steps.
    add(4'b0000, 0, 0, 0, 0, 0, 8'h00, 8'd0);
    add(4'b0110, 0, 0, 0, 0, 0, 8'h00, 8'd0);
    add(4'b0001, 0, 0, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0010, 1, 1, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0100, 1, 1, 0, 1, 0, 8'h00, 8'd0);
    add(4'b1000, 1, 1, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0001, 1, 1, 0, 1, 0, 8'h00, 8'd0);
    // Downward wrap-around from 0001.
    add(4'b1000, 1, 0, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0100, 1, 0, 0, 1, 0, 8'h00, 8'd0);
    run_tbl();

    // Word 1,0,1,1,0,0,1,0 -> B2.
    do_reset("rst_mid_a");
    add(4'b0001, 0, 0, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0010, 1, 1, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0001, 1, 0, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0010, 1, 1, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0100, 1, 1, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0010, 1, 0, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0001, 1, 0, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0010, 1, 1, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0001, 1, 0, 0, 1, 1, 8'hB2, 8'd0);
    // Three bits, illegal code, relock; next word needs 8 fresh bits (E3).
    add(4'b0010, 1, 1, 0, 1, 0, 8'hB2, 8'd0);
    add(4'b0100, 1, 1, 0, 1, 0, 8'hB2, 8'd0);
    add(4'b1000, 1, 1, 0, 1, 0, 8'hB2, 8'd0);
    add(4'b0011, 0, 0, 1, 0, 0, 8'hB2, 8'd1);
    add(4'b0100, 0, 0, 0, 1, 0, 8'hB2, 8'd1);
    add(4'b1000, 1, 1, 0, 1, 0, 8'hB2, 8'd1);
    add(4'b0001, 1, 1, 0, 1, 0, 8'hB2, 8'd1);
    add(4'b0010, 1, 1, 0, 1, 0, 8'hB2, 8'd1);
    add(4'b0001, 1, 0, 0, 1, 0, 8'hB2, 8'd1);
    add(4'b1000, 1, 0, 0, 1, 0, 8'hB2, 8'd1);
    add(4'b0100, 1, 0, 0, 1, 0, 8'hB2, 8'd1);
    add(4'b1000, 1, 1, 0, 1, 0, 8'hB2, 8'd1);
    add(4'b0001, 1, 1, 0, 1, 1, 8'hE3, 8'd1);
    run_tbl();

    // Hold and skip jumps keep lock and count errors.
    do_reset("rst_mid_b");
    add(4'b0010, 0, 0, 0, 1, 0, 8'h00, 8'd0);
    add(4'b0010, 0, 0, 1, 1, 0, 8'h00, 8'd1);
    add(4'b1000, 0, 0, 1, 1, 0, 8'h00, 8'd2);
    // 300 held codes: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      add(4'b1000, 0, 0, 1, 1, 0, 8'h00, (i + 3 > 255) ? 8'd255 : 8'(i + 3));
    end
    add(4'b0000, 0, 0, 1, 0, 0, 8'h00, 8'd255);
    add(4'b0001, 0, 0, 0, 1, 0, 8'h00, 8'd255);
    add(4'b0010, 1, 1, 0, 1, 0, 8'h00, 8'd255);
    add(4'b0100, 1, 1, 0, 1, 0, 8'h00, 8'd255);
    run_tbl();

    // Mid-word reset with Xvalid high and saturated err_count.
    do_reset("rst_mid_c");
    add(4'b0100, 0, 0, 0, 1, 0, 8'h00, 8'd0);
    add(4'b1000, 1, 1, 0, 1, 0, 8'h00, 8'd0);
    run_tbl();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
